// File: rtl/div_seq_32.sv
// Multi-cycle restoring divider that drives an external adder_32 in subtract mode for N iterations.
// Optional signed support (i_signed port, magnitude pre/post-processing) is enabled by defining DIV_SIGNED_EN.
module div_seq_32 #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
`ifdef DIV_SIGNED_EN
    input  logic         i_signed,
`endif
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic [N-1:0] o_add_x,
    output logic [N-1:0] o_add_y,
    output logic         o_add_t,
    input  logic [N-1:0] i_add_s,
    input  logic         i_add_cout
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [N-1:0]     r_reg, q_reg, d_reg;
    logic [N-1:0]     quotient_reg, remainder_reg;
    logic             neg_q_reg, neg_r_reg;

    logic [N-1:0]     dvd_mag, dvs_mag;
    logic             neg_q_in, neg_r_in;

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    assign dvd_neg  = i_signed & i_dividend[N-1];
    assign dvs_neg  = i_signed & i_divisor[N-1];
    assign dvd_mag  = dvd_neg ? ({N{1'b0}} - i_dividend) : i_dividend;
    assign dvs_mag  = dvs_neg ? ({N{1'b0}} - i_divisor) : i_divisor;
    // A zero divisor keeps the all-ones quotient unsigned-looking.
    assign neg_q_in = (dvd_neg ^ dvs_neg) & (i_divisor != {N{1'b0}});
    assign neg_r_in = dvd_neg;
`else
    assign dvd_mag  = i_dividend;
    assign dvs_mag  = i_divisor;
    assign neg_q_in = 1'b0;
    assign neg_r_in = 1'b0;
`endif

    // One restoring step: shift {R,Q} left, keep the difference if no borrow.
    logic         shift_msb, success, last_iter;
    logic [N-1:0] shift_x, r_step, q_step;

    assign shift_msb = r_reg[N-1];
    assign shift_x   = {r_reg[N-2:0], q_reg[N-1]};
    assign success   = shift_msb | i_add_cout;
    assign r_step    = success ? i_add_s : shift_x;
    assign q_step    = {q_reg[N-2:0], success};
    assign last_iter = (cnt_reg == CNT_W'(N - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state_reg != IDLE);
        o_done  = (state_reg == DONE);
        o_add_t = (state_reg == RUN);
        o_add_x = (state_reg == RUN) ? shift_x : {N{1'b0}};
        o_add_y = (state_reg == RUN) ? d_reg : {N{1'b0}};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg       <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        cnt_reg   <= '0;
                        r_reg     <= '0;
                        q_reg     <= dvd_mag;
                        d_reg     <= dvs_mag;
                        neg_q_reg <= neg_q_in;
                        neg_r_reg <= neg_r_in;
                    end
                end
                RUN: begin
                    r_reg   <= r_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        quotient_reg  <= neg_q_reg ? ({N{1'b0}} - q_step) : q_step;
                        remainder_reg <= neg_r_reg ? ({N{1'b0}} - r_step) : r_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient  = quotient_reg;
    assign o_remainder = remainder_reg;

endmodule

// File: tb/tb_div_seq_32.sv
// Bench for div_seq_32: models adder_32 behaviourally and checks results against plain arithmetic.
module tb_div_seq_32;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [31:0] i_dividend, i_divisor;
    logic        i_signed;
    logic        o_busy, o_done, o_add_t;
    logic [31:0] o_quotient, o_remainder, o_add_x, o_add_y;
    logic [31:0] add_s;
    logic        add_cout;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    // adder_32: S = X + ~Y + T, Cout is the carry out of bit 31.
    assign {add_cout, add_s} = {1'b0, o_add_x} + {1'b0, ~o_add_y} + {32'd0, o_add_t};

    div_seq_32 dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
`ifdef DIV_SIGNED_EN
        .i_signed    (i_signed),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_add_x     (o_add_x),
        .o_add_y     (o_add_y),
        .o_add_t     (o_add_t),
        .i_add_s     (add_s),
        .i_add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Issue one divide, scramble the operands afterwards, and check timing and results.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] eq, er, ey;
        int cyc;
        ref_div(a, b, s, eq, er);
        ey = (s && b[31]) ? (32'd0 - b) : b;
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = a; i_divisor = b; i_signed = s;
        @(negedge i_clk);
        i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
        cyc = 1;
        chk("run_add_t", {31'd0, o_add_t}, 32'd1);
        chk("run_add_y", o_add_y, ey);
        while (!o_done && cyc < 40) begin
            if (!o_busy) chk("busy_in_run", {31'd0, o_busy}, 32'd1);
            @(negedge i_clk);
            cyc++;
        end
        chk("done_cycle", cyc, 33);
        chk("done_busy", {31'd0, o_busy}, 32'd1);
        chk("quotient", o_quotient, eq);
        chk("remainder", o_remainder, er);
        $display("op a=%h b=%h s=%0d -> q=%h r=%h (exp q=%h r=%h) cycle=%0d",
                 a, b, s, o_quotient, o_remainder, eq, er, cyc);
        @(negedge i_clk);
        chk("idle_done", {31'd0, o_done}, 32'd0);
        chk("idle_add_t", {31'd0, o_add_t}, 32'd0);
        chk("hold_quotient", o_quotient, eq);
    endtask

    initial begin
        logic [31:0] a, b, hq, hr;
        int done_cnt, done_at;

        i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0; i_signed = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_quotient", o_quotient, 32'd0);
        chk("rst_remainder", o_remainder, 32'd0);
        chk("rst_add_x", o_add_x, 32'd0);
        chk("rst_add_y", o_add_y, 32'd0);
        i_rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(32'd5, 32'd0, 1'b0);
        do_op(32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : ($urandom >> $urandom_range(0, 31));
            do_op(a, b, 1'b0);
        end

        // start held high with changing operands until cycle 20
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = 32'd1000; i_divisor = 32'd7;
        done_cnt = 0; done_at = 0; hq = '0; hr = '0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge i_clk);
            if (c <= 20) begin
                i_dividend = $urandom; i_divisor = $urandom;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                done_cnt++;
                done_at = c;
                hq = o_quotient;
                hr = o_remainder;
            end
        end
        $display("held start: done_cnt=%0d at cycle %0d q=%h r=%h", done_cnt, done_at, hq, hr);
        chk("held_done_count", done_cnt, 1);
        chk("held_done_cycle", done_at, 33);
        chk("held_quotient", hq, 32'd142);
        chk("held_remainder", hr, 32'd6);

        // reset pulse in cycle 15 of an operation
        @(negedge i_clk);
        i_start = 1'b1; i_dividend = 32'd1000; i_divisor = 32'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (13) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        chk("abort_quotient", o_quotient, 32'd0);
        chk("abort_remainder", o_remainder, 32'd0);
        chk("abort_add_x", o_add_x, 32'd0);
        chk("abort_add_t", {31'd0, o_add_t}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            if (o_done || o_busy) done_cnt++;
        end
        $display("after abort: active cycles=%0d", done_cnt);
        chk("abort_no_done", done_cnt, 0);
        do_op(32'd9, 32'd3, 1'b0);

`ifdef DIV_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            do_op(a, b, 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
